// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32I instruction-fetch stage with one-outstanding imem fetch and skid buffer
`timescale 1ns/1ps

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        stall_if,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        valid
);

  typedef enum logic {S_READY, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] sk_pc_q, sk_pc_d;
  logic [31:0] sk_instr_q, sk_instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        discard_q, discard_d;
  logic        sk_full_q, sk_full_d;
  logic        valid_q, valid_d;

  logic resp;
  logic to_out;
  logic to_skid;
  logic fire;

  // A live response is one for the current path: not squashed by an earlier or concurrent flush.
  assign resp    = (state_q == S_WAIT) && imem_rvalid && !discard_q && !flush;
  assign to_out  = resp && (!valid_q || !stall_if) && !sk_full_q;
  assign to_skid = resp && !to_out;
  assign fire    = imem_req && imem_gnt;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q    <= S_READY;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      discard_q  <= 1'b0;
      sk_pc_q    <= 32'h0;
      sk_instr_q <= 32'h0;
      sk_full_q  <= 1'b0;
      pc_q       <= 32'h0;
      instr_q    <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      discard_q  <= discard_d;
      sk_pc_q    <= sk_pc_d;
      sk_instr_q <= sk_instr_d;
      sk_full_q  <= sk_full_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    if (fire) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
      state_d    = S_WAIT;
    end else if (state_q == S_WAIT && imem_rvalid) begin
      state_d   = S_READY;
      discard_d = 1'b0;
    end
    // The in-flight fetch cannot be cancelled, so its response is marked for dropping.
    if (flush) begin
      fetch_pc_d = {branch_target[31:2], 2'b00};
      if (state_q == S_WAIT && !imem_rvalid) begin
        discard_d = 1'b1;
      end
    end
  end

  always_comb begin
    imem_addr = fetch_pc_q;
    if (state_q == S_READY) begin
      imem_req = rst_ && !sk_full_q && !flush;
    end else begin
      imem_req = rst_ && to_out;
    end

    sk_pc_d    = sk_pc_q;
    sk_instr_d = sk_instr_q;
    sk_full_d  = sk_full_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    if (to_skid) begin
      sk_pc_d    = req_pc_q;
      sk_instr_d = imem_rdata;
      sk_full_d  = 1'b1;
    end
    if (flush) begin
      valid_d   = 1'b0;
      sk_full_d = 1'b0;
    end else if (!(valid_q && stall_if)) begin
      if (sk_full_q) begin
        pc_d      = sk_pc_q;
        instr_d   = sk_instr_q;
        valid_d   = 1'b1;
        sk_full_d = to_skid;
      end else if (to_out) begin
        pc_d    = req_pc_q;
        instr_d = imem_rdata;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  assign pc    = pc_q;
  assign instr = instr_q;
  assign valid = valid_q;

endmodule
